// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: sequences CPU load/store requests onto a 16-bit single-port data SRAM.
// Latency: load byte/half 3 cycles, word 4; store half 2, byte (read-modify-write) 3, word 3; bad funct3 1.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Optional build macro MISALIGN_TRAP_EN: odd-address halfword/word accesses return resp_err
// without touching memory; when undefined, req_addr[0] is ignored for those sizes.
module dmem_port_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_s_byte,
  output logic            resp_err,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [AW-2:0]   mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic [15:0]     mem_rdata
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] RD_LO  = 4'd1;
  localparam logic [3:0] RD_HI  = 4'd2;
  localparam logic [3:0] LAT    = 4'd3;
  localparam logic [3:0] LAT_HI = 4'd4;
  localparam logic [3:0] RMW_RD = 4'd5;
  localparam logic [3:0] RMW_WR = 4'd6;
  localparam logic [3:0] WR_LO  = 4'd7;
  localparam logic [3:0] WR_HI  = 4'd8;
  localparam logic [3:0] RESP   = 4'd9;

  localparam logic [AW-2:0] HA_ONE = {{(AW-2){1'b0}}, 1'b1};

  logic [3:0]      state_q, state_d;
  logic [AW-2:0]   ha_q, ha_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            sbyte_q, sbyte_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            acc_err;

  // Classify the incoming request: unsupported size/sign combos, plus optional misalignment trap.
  always_comb begin
    acc_err = (req_funct3[1:0] == 2'b11) || (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
    if (req_addr[0] && ((req_funct3[1:0] == 2'b01) || (req_funct3[1:0] == 2'b10))) begin
      acc_err = 1'b1;
    end
`else
    acc_err = acc_err;
`endif
  end

  // Sequencer next-state and capture of request fields / read data.
  always_comb begin
    state_d = state_q;
    ha_d    = ha_q;
    wdata_d = wdata_q;
    sbyte_d = sbyte_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ha_d    = req_addr[AW-1:1];
          wdata_d = req_wdata;
          sbyte_d = req_addr[0];
          word_d  = (req_funct3[1:0] == 2'b10);
          rdata_d = '0;
          err_d   = acc_err;
          if (acc_err) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD_LO;
          end else if (req_funct3[1:0] == 2'b00) begin
            state_d = RMW_RD;
          end else begin
            state_d = WR_LO;
          end
        end
      end
      RD_LO:  state_d = word_q ? RD_HI : LAT;
      RD_HI: begin
        rdata_d[15:0] = mem_rdata;
        state_d       = LAT_HI;
      end
      LAT: begin
        rdata_d[15:0] = mem_rdata;
        state_d       = RESP;
      end
      LAT_HI: begin
        rdata_d[XLEN-1:16] = mem_rdata;
        state_d            = RESP;
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: state_d = RESP;
      WR_LO:  state_d = word_q ? WR_HI : RESP;
      WR_HI:  state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ha_q    <= '0;
      wdata_q <= '0;
      sbyte_q <= 1'b0;
      word_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ha_q    <= ha_d;
      wdata_q <= wdata_d;
      sbyte_q <= sbyte_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes and address/data decoded from state; idle bus is driven to zero.
  always_comb begin
    mem_rd    = (state_q == RD_LO) || (state_q == RD_HI) || (state_q == RMW_RD);
    mem_wr    = (state_q == WR_LO) || (state_q == WR_HI) || (state_q == RMW_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == RD_HI) || (state_q == WR_HI)) begin
      mem_addr = ha_q + HA_ONE;
    end else if (mem_rd || mem_wr) begin
      mem_addr = ha_q;
    end
    // The byte merge uses the read data arriving this cycle from the RMW_RD strobe.
    if (state_q == WR_LO) begin
      mem_wdata = wdata_q[15:0];
    end else if (state_q == WR_HI) begin
      mem_wdata = wdata_q[31:16];
    end else if (state_q == RMW_WR) begin
      mem_wdata = sbyte_q ? {wdata_q[7:0], mem_rdata[7:0]} : {mem_rdata[15:8], wdata_q[7:0]};
    end
  end

  // Handshake and response outputs.
  always_comb begin
    req_ready   = (state_q == IDLE) && !rst;
    resp_valid  = (state_q == RESP);
    resp_data   = rdata_q;
    resp_s_byte = sbyte_q;
    resp_err    = err_q;
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
module tb_dmem_port_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_s_byte, resp_err;
  logic        mem_rd, mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  dmem_port_ctrl #(.XLEN(32), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_s_byte(resp_s_byte), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Expected activity for one cycle of a transaction.
  typedef struct {
    bit        rd;
    bit        wr;
    bit [14:0] addr;
    bit [15:0] wd;
    bit        rv;
    bit [31:0] rdata;
    bit        err;
    bit        sb;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] sram    [0:32767];
  logic [15:0] ref_mem [0:32767];
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_data;
  logic        last_err, last_sb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: read data appears the cycle after the strobe.
  initial mem_rdata = 16'h0;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= sram[mem_addr];
    if (mem_wr) sram[mem_addr] = mem_wdata;
  end

  task automatic set_mem(input bit [14:0] idx, input bit [15:0] val);
    sram[idx]    = val;
    ref_mem[idx] = val;
  endtask

  function automatic rec_t mk(input bit rd, input bit wr, input bit [14:0] a, input bit [15:0] wd);
    rec_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wd = wd;
    r.rv = 1'b0; r.rdata = 32'h0; r.err = 1'b0; r.sb = 1'b0;
    return r;
  endfunction

  // Reference model: what one request must do to memory and return, cycle by cycle.
  task automatic model_req(input bit we, input bit [2:0] f3, input bit [15:0] addr,
                           input bit [31:0] wd, input int h, output int n);
    bit [14:0] ha, ha1;
    bit [15:0] old, nw;
    bit [31:0] data;
    bit        err;
    rec_t      r;
    ha   = addr[15:1];
    ha1  = ha + 15'd1;
    data = 32'h0;
    err  = (f3[1:0] == 2'b11) || (we && f3[2]);
`ifdef MISALIGN_TRAP_EN
    if (addr[0] && (f3[1:0] == 2'b01 || f3[1:0] == 2'b10)) err = 1'b1;
`endif
    if (err) begin
      n = 1;
    end else if (!we) begin
      if (f3[1:0] == 2'b10) begin
        exp_q.push_back(mk(1, 0, ha, 0));
        exp_q.push_back(mk(1, 0, ha1, 0));
        exp_q.push_back(mk(0, 0, 0, 0));
        data = {ref_mem[ha1], ref_mem[ha]};
        n = 4;
      end else begin
        exp_q.push_back(mk(1, 0, ha, 0));
        exp_q.push_back(mk(0, 0, 0, 0));
        data = {16'h0, ref_mem[ha]};
        n = 3;
      end
    end else if (f3[1:0] == 2'b00) begin
      old = ref_mem[ha];
      nw  = addr[0] ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]};
      exp_q.push_back(mk(1, 0, ha, 0));
      exp_q.push_back(mk(0, 1, ha, nw));
      ref_mem[ha] = nw;
      n = 3;
    end else if (f3[1:0] == 2'b01) begin
      exp_q.push_back(mk(0, 1, ha, wd[15:0]));
      ref_mem[ha] = wd[15:0];
      n = 2;
    end else begin
      exp_q.push_back(mk(0, 1, ha, wd[15:0]));
      exp_q.push_back(mk(0, 1, ha1, wd[31:16]));
      ref_mem[ha]  = wd[15:0];
      ref_mem[ha1] = wd[31:16];
      n = 3;
    end
    for (int i = 0; i <= h; i++) begin
      r = mk(0, 0, 0, 0);
      r.rv = 1'b1; r.rdata = data; r.err = err; r.sb = addr[0];
      exp_q.push_back(r);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    rec_t r;
    if (chk_en && !rst) begin
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("busy_req_ready", 32'(req_ready), 32'(0));
        chk("mem_rd", 32'(mem_rd), 32'(r.rd));
        chk("mem_wr", 32'(mem_wr), 32'(r.wr));
        if (r.rd || r.wr) chk("mem_addr", 32'(mem_addr), 32'(r.addr));
        if (r.wr) chk("mem_wdata", 32'(mem_wdata), 32'(r.wd));
        chk("resp_valid", 32'(resp_valid), 32'(r.rv));
        if (r.rv) begin
          chk("resp_data", resp_data, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_s_byte", 32'(resp_s_byte), 32'(r.sb));
          last_data = resp_data;
          last_err  = resp_err;
          last_sb   = resp_s_byte;
        end
      end else begin
        chk("idle_req_ready", 32'(req_ready), 32'(1));
        chk("idle_mem_rd", 32'(mem_rd), 32'(0));
        chk("idle_mem_wr", 32'(mem_wr), 32'(0));
        chk("idle_resp_valid", 32'(resp_valid), 32'(0));
      end
    end
  end

  // Issue one request from an idle cycle; returns in the idle cycle after completion.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [15:0] addr,
                        input bit [31:0] wd, input int h);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (h == 0);
    @(posedge clk);
    model_req(we, f3, addr, wd, h, n);
    #2;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = $urandom;
    if (h == 0) begin
      repeat (n) @(posedge clk);
    end else begin
      repeat (n + h - 1) @(posedge clk);
      #2 resp_ready = 1'b1;
      @(posedge clk);
    end
    #2;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    req_addr = 16'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    last_data = 32'h0; last_err = 1'b0; last_sb = 1'b0;
    for (int i = 0; i < 32768; i++) set_mem(15'(i), 16'((i * 40503) ^ 16'h5AA5));
    set_mem(15'h0008, 16'hBEEF);
    set_mem(15'h0009, 16'hDEAD);
    set_mem(15'h0010, 16'h1234);
    set_mem(15'h0001, 16'h5A5A);
    set_mem(15'h7FFF, 16'h1111);
    set_mem(15'h0000, 16'h2222);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_mem_rd", 32'(mem_rd), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #2;

    do_req(1'b0, 3'b010, 16'h0010, 32'h0, 0);
    chk("lw_pin_data", last_data, 32'hDEADBEEF);
    chk("lw_pin_err", 32'(last_err), 32'(0));

    do_req(1'b1, 3'b000, 16'h0021, 32'h000000AB, 0);
    chk("sb_hi_pin_mem", 32'(sram[15'h0010]), 32'h0000AB34);
    chk("sb_hi_pin_sbyte", 32'(last_sb), 32'(1));

    do_req(1'b1, 3'b000, 16'h0020, 32'hFFFFFFCD, 0);
    chk("sb_lo_pin_mem", 32'(sram[15'h0010]), 32'h0000ABCD);

    do_req(1'b0, 3'b000, 16'h0021, 32'h0, 1);
    chk("lb_pin_data", last_data, 32'h0000ABCD);

    do_req(1'b1, 3'b010, 16'h0004, 32'hCAFEF00D, 5);
    chk("sw_pin_lo", 32'(sram[15'h0002]), 32'h0000F00D);
    chk("sw_pin_hi", 32'(sram[15'h0003]), 32'h0000CAFE);

    do_req(1'b0, 3'b110, 16'h0004, 32'h0, 0);
    chk("lwu_pin_data", last_data, 32'hCAFEF00D);

    do_req(1'b0, 3'b011, 16'h0010, 32'h0, 0);
    chk("ld_pin_err", 32'(last_err), 32'(1));
    chk("ld_pin_data", last_data, 32'h0);
    do_req(1'b1, 3'b011, 16'h0010, 32'h12345678, 0);
    do_req(1'b0, 3'b111, 16'h0010, 32'h0, 2);
    do_req(1'b1, 3'b100, 16'h0010, 32'h12345678, 0);

    do_req(1'b0, 3'b010, 16'hFFFE, 32'h0, 0);
    chk("lw_wrap_pin", last_data, 32'h22221111);
    do_req(1'b1, 3'b010, 16'hFFFE, 32'h76543210, 2);
    chk("sw_wrap_pin_lo", 32'(sram[15'h7FFF]), 32'h00003210);
    chk("sw_wrap_pin_hi", 32'(sram[15'h0000]), 32'h00007654);

    do_req(1'b0, 3'b001, 16'h0003, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("lh_odd_pin_err", 32'(last_err), 32'(1));
    chk("lh_odd_pin_data", last_data, 32'h0);
`else
    chk("lh_odd_pin_err", 32'(last_err), 32'(0));
    chk("lh_odd_pin_data", last_data, 32'h00005A5A);
`endif

    do_req(1'b1, 3'b001, 16'h0040, 32'h9999BEAD, 0);
    do_req(1'b0, 3'b101, 16'h0040, 32'h0, 0);
    chk("lhu_pin_data", last_data, 32'h0000BEAD);

    // Reset in the middle of the high-half read of a word load.
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010;
    @(posedge clk);
    #2 req_valid = 1'b0;
    chk("mid_rdlo_rd", 32'(mem_rd), 32'(1));
    @(posedge clk);
    #2;
    chk("mid_rdhi_rd", 32'(mem_rd), 32'(1));
    chk("mid_rdhi_addr", 32'(mem_addr), 32'h9);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'(0));
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_req_ready", 32'(req_ready), 32'(1));
    chk_en = 1'b1;
    do_req(1'b0, 3'b001, 16'h0012, 32'h0, 0);
    chk("post_rst_lh_pin", last_data, 32'h0000DEAD);

    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
